mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares one external single-port memory bus between the core's instruction-fetch path and its data-memory path. Each requester issues level requests. The arbiter grants one transaction at a time, drives the shared bus, and routes read data back to the owner. Data requests have priority, bounded by an anti-starvation counter for fetch. It sits between the core's fetch/dmem stages and the off-core memory; its stall outputs feed the pipeline stall logic.

## Interface
- AW, 32, address width
- DW, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits (1..15)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch read request (level)
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted by bus (1-cycle pulse)
- if_rvalid  out  1  fetch read data valid (1-cycle pulse)
- if_rdata  out  DW  fetch read data
- if_stall  out  1  if_req high and not granted this cycle
- d_req  in  1  data request (level)
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_wstrb  in  DW/8  byte enables
- d_gnt, d_rvalid, d_rdata, d_stall  out  1/1/DW/1  as for fetch
- m_req  out  1  bus request
- m_we, m_addr, m_wdata, m_wstrb  out  1/AW/DW/DW/8  registered bus command
- m_ready  in  1  bus accepts command when m_req & m_ready
- m_rvalid  in  1  read data return
- m_rdata  in  DW  read data

## Operation
- FSM: IDLE, ISSUE, WAIT_RD. Only one transaction is outstanding at a time.
- IDLE, arbitration:
  - if both request and starve_cnt < STARVE_MAX, data wins; otherwise the sole requester wins, or fetch wins when starve_cnt == STARVE_MAX.
  - Winner's command is registered into m_*, owner is latched, m_req <= 1, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - m_req and m_* are held stable until m_ready.
  - On m_req & m_ready, the owner's gnt = 1 (combinational, same cycle) and m_req <= 0.
  - On acceptance, a write goes to IDLE; a read goes to WAIT_RD.
- WAIT_RD: on m_rvalid, m_rdata is registered into the owner's rdata, the owner's rvalid pulses next cycle, and the FSM returns to IDLE.
- m_rvalid outside WAIT_RD is ignored. Fetch never writes: m_we = 0 and m_wstrb = 0 for fetch grants.
- starve_cnt (4 bits):
  - Increments, saturating at STARVE_MAX, on each data grant while if_req = 1.
  - Clears on a fetch grant or whenever if_req = 0 in IDLE.
- Requesters hold req/addr/wdata stable until gnt. A req still high after gnt is a new request.
- x_stall = x_req & ~x_gnt.
- x_rdata holds its last value between pulses.
- In IDLE, ISSUE and WAIT_RD, m_addr/m_wdata are zero except while the command is being presented.

## Timing
- Reset (async, active-high):
  - State is IDLE, starve_cnt = 0, owner = fetch.
  - All outputs are 0: m_req, m_*, gnt, rvalid, rdata.
  - An in-flight read is dropped; a later m_rvalid is ignored.
- Request sampled in IDLE at cycle N: m_req = 1 from N+1.
- Acceptance at cycle A (m_ready = 1):
  - gnt pulses at A.
  - For a write, the FSM is in IDLE at A+1 and the next m_req is at A+2.
- Read: m_rvalid is legal from A+1. With m_rvalid at K, x_rvalid and x_rdata are valid at K+1, the FSM is in IDLE at K+1, and the next m_req is at K+2.
- Best-case read: req N, m_req/accept N+1, m_rvalid N+2, rvalid N+3.
- Best-case back-to-back writes: one every 2 cycles.
- Simultaneous first requests: data wins. A fetch waiting behind continuous data traffic is granted after at most STARVE_MAX data grants.
- m_ready stalls of arbitrary length are legal; m_* stay unchanged.

## Test plan
- Single fetch read at 0x100, m_ready = 1, m_rvalid 1 cycle after accept with m_rdata = 0xDEADBEEF -> if_gnt at N+1, if_rvalid = 1 with if_rdata = 0xDEADBEEF at N+3, d_rvalid = 0.
- Data write 0x200 / 0x12345678 / wstrb 0xF with m_ready low for 3 cycles -> m_req and m_* stable for 4 cycles, d_stall = 1 until the d_gnt cycle, no rvalid pulses.
- Both requesters high continuously, STARVE_MAX = 4, data reads back-to-back -> grant order D,D,D,D,F,D,D,D,D,F.
- Simultaneous if_req and d_req read, then m_rvalid = 0xAA -> d_rvalid = 1 with d_rdata = 0xAA, if_rvalid = 0; fetch is granted next.
- rst asserted in WAIT_RD, released, then a stray m_rvalid -> all outputs 0 during reset, no rvalid pulse, FSM IDLE.
- Spurious m_rvalid in IDLE and ISSUE -> ignored; a subsequent genuine read returns correct data.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared-memory bus signals around the memory port arbiter.
// The arbiter uses the slave view; the core/memory side uses the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          if_stall;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wstrb;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            d_stall;

  logic            m_req;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic            m_ready;
  logic            m_rvalid;
  logic [DW-1:0]   m_rdata;

  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  m_ready, m_rvalid, m_rdata,
    output if_gnt, if_rvalid, if_rdata, if_stall,
    output d_gnt, d_rvalid, d_rdata, d_stall,
    output m_req, m_we, m_addr, m_wdata, m_wstrb
  );

  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    output m_ready, m_rvalid, m_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_stall,
    input  d_gnt, d_rvalid, d_rdata, d_stall,
    input  m_req, m_we, m_addr, m_wdata, m_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory bus between instruction fetch and data access, one
// transaction at a time; data has priority, bounded by a fetch anti-starvation counter.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t          state;
  logic            owner_data;
  logic [3:0]      starve_cnt;

  logic            accept;
  logic            any_req;
  logic            data_wins;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_wdata;
  logic [DW/8-1:0] win_wstrb;
  logic            win_we;

  // Fetch only overrides data priority once it has watched STARVE_MAX data grants go by.
  assign any_req   = bus.if_req | bus.d_req;
  assign data_wins = bus.d_req & (~bus.if_req | (starve_cnt < STARVE_LIM));
  assign win_addr  = data_wins ? bus.d_addr : bus.if_addr;
  assign win_wdata = data_wins ? bus.d_wdata : '0;
  assign win_wstrb = data_wins ? bus.d_wstrb : '0;
  assign win_we    = data_wins & bus.d_we;

  assign accept       = (state == ISSUE) & bus.m_ready;
  assign bus.if_gnt   = accept & ~owner_data;
  assign bus.d_gnt    = accept & owner_data;
  assign bus.if_stall = bus.if_req & ~bus.if_gnt;
  assign bus.d_stall  = bus.d_req & ~bus.d_gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner_data    <= 1'b0;
      starve_cnt    <= '0;
      bus.m_req     <= 1'b0;
      bus.m_we      <= 1'b0;
      bus.m_addr    <= '0;
      bus.m_wdata   <= '0;
      bus.m_wstrb   <= '0;
      bus.if_rvalid <= 1'b0;
      bus.if_rdata  <= '0;
      bus.d_rvalid  <= 1'b0;
      bus.d_rdata   <= '0;
    end else begin
      bus.if_rvalid <= 1'b0;
      bus.d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.if_req) starve_cnt <= '0;
          if (any_req) begin
            owner_data  <= data_wins;
            bus.m_req   <= 1'b1;
            bus.m_we    <= win_we;
            bus.m_addr  <= win_addr;
            bus.m_wdata <= win_wdata;
            bus.m_wstrb <= win_wstrb;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.m_ready) begin
            bus.m_req   <= 1'b0;
            bus.m_we    <= 1'b0;
            bus.m_addr  <= '0;
            bus.m_wdata <= '0;
            bus.m_wstrb <= '0;
            if (!owner_data) begin
              starve_cnt <= '0;
            end else if (bus.if_req && (starve_cnt < STARVE_LIM)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
            state <= bus.m_we ? IDLE : WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (bus.m_rvalid) begin
            if (owner_data) begin
              bus.d_rvalid <= 1'b1;
              bus.d_rdata  <= bus.m_rdata;
            end else begin
              bus.if_rvalid <= 1'b1;
              bus.if_rdata  <= bus.m_rdata;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
